// File: rtl/scrambler_par.sv
// scrambler_par: 802.11a x^7+x^4+1 scrambler (TX) / self-synchronising descrambler (RX), DATA_W bits per beat
//   clk_i, rst_i (async, active-high); start_i latches mode_i (0 TX, 1 RX) and reinitialises the LFSR
//   en_i/data_i input beat (bit 0 earliest); out_o/out_valid_o registered result one cycle later
//   locked_o LFSR state known; state_out_o LFSR {x7..x1} captured when lock is reached
//   Optional SCRAMBLER_BYPASS_EN adds bypass_i: data passes through registered, LFSR and counter frozen
module scrambler_par #(
  parameter int DATA_W = 1,
  parameter logic [6:0] SEED = 7'b1011101
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic              bypass_i,
`endif
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid_o,
  output logic              locked_o,
  output logic [6:0]        state_out_o
);
  typedef enum logic [1:0] {IDLE, RECOVER, RUN} state_t;
  state_t state_q, state_d, state_b;
  logic mode_q, mode_b, byp, step, s;
  logic [6:0] lfsr_q, lfsr_d, lfsr_b, lfsr_c, cap_c, state_out_q, state_out_d;
  logic [2:0] cnt_q, cnt_d, cnt_b, cnt_c;
  logic [DATA_W-1:0] out_q, out_d, out_c;
  logic out_valid_q, out_valid_d, locked_q, locked_d;
`ifdef SCRAMBLER_BYPASS_EN
  assign byp = bypass_i;
`else
  assign byp = 1'b0;
`endif
  // A start in the same cycle as a beat initialises first; the beat then runs from the fresh state.
  always_comb begin
    state_b = start_i ? (mode_i ? RECOVER : RUN) : state_q;
    mode_b = start_i ? mode_i : mode_q;
    lfsr_b = start_i ? (mode_i ? 7'd0 : SEED) : lfsr_q;
    cnt_b = start_i ? 3'd0 : cnt_q;
    lfsr_c = lfsr_b;
    cnt_c = cnt_b;
    cap_c = lfsr_b;
    out_c = '0;
    s = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      s = lfsr_c[6] ^ lfsr_c[3];
      // RX recovery: the leading SERVICE zeros arrive as raw scrambler output, so shift them straight in.
      if (mode_b && cnt_c != 3'd7) begin
        lfsr_c = {lfsr_c[5:0], data_i[i]};
        cnt_c = cnt_c + 3'd1;
        cap_c = lfsr_c;
      end else begin
        out_c[i] = data_i[i] ^ s;
        lfsr_c = {lfsr_c[5:0], s};
      end
    end
    step = en_i && state_b != IDLE && !byp;
    lfsr_d = step ? lfsr_c : lfsr_b;
    cnt_d = step ? cnt_c : cnt_b;
    state_d = (step && state_b == RECOVER && cnt_c == 3'd7) ? RUN : state_b;
    locked_d = state_d == RUN;
    state_out_d = (start_i && !mode_i) ? SEED :
                  (state_b == RECOVER && state_d == RUN) ? cap_c : state_out_q;
    out_valid_d = byp ? en_i : en_i && state_b != IDLE;
    out_d = byp ? (en_i ? data_i : out_q) : (step ? out_c : out_q);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      lfsr_q <= 7'd0;
      cnt_q <= 3'd0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      locked_q <= 1'b0;
      state_out_q <= 7'd0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_b;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      locked_q <= locked_d;
      state_out_q <= state_out_d;
    end
  end
  assign out_o = out_q;
  assign out_valid_o = out_valid_q;
  assign locked_o = locked_q;
  assign state_out_o = state_out_q;
endmodule

// File: tb/tb_scrambler_par.sv
// tb_scrambler_par: scoreboard bench for scrambler_par (serial TX/RX, 8-bit TX, 4-bit TX->RX loopback)
module tb_scrambler_par;
  logic clk, rst;
  int n_cmp, n_bad;
  logic s1, m1, e1, d1, b1, o1, v1, l1;
  logic [6:0] so1;
  logic s8, m8, e8, v8, l8;
  logic [7:0] d8, o8;
  logic [6:0] so8;
  logic st, mt, et, vt, lt, sr, mr, vr, lr;
  logic [3:0] dt, ot, orx;
  logic [6:0] sot, sor;
  logic q1[$];
  logic [7:0] q8[$];
  logic [3:0] qr[$];
  logic [3:0] vec[31];
  logic [7:0] seq, nxt;
  logic [6:0] rxb;
  logic x1;
  logic [7:0] x8;
  logic [3:0] xr;

  scrambler_par #(.DATA_W(1), .SEED(7'b1111111)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(s1), .mode_i(m1), .en_i(e1), .data_i(d1),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass_i(b1),
`endif
    .out_o(o1), .out_valid_o(v1), .locked_o(l1), .state_out_o(so1));
  scrambler_par #(.DATA_W(8), .SEED(7'b1111111)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(s8), .mode_i(m8), .en_i(e8), .data_i(d8),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .out_o(o8), .out_valid_o(v8), .locked_o(l8), .state_out_o(so8));
  scrambler_par #(.DATA_W(4)) ut (
    .clk_i(clk), .rst_i(rst), .start_i(st), .mode_i(mt), .en_i(et), .data_i(dt),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .out_o(ot), .out_valid_o(vt), .locked_o(lt), .state_out_o(sot));
  scrambler_par #(.DATA_W(4)) ur (
    .clk_i(clk), .rst_i(rst), .start_i(sr), .mode_i(mr), .en_i(vt), .data_i(ot),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .out_o(orx), .out_valid_o(vr), .locked_o(lr), .state_out_o(sor));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task beat1(input logic d, input logic exp);
    d1 = d;
    e1 = 1'b1;
    q1.push_back(exp);
    tick;
  endtask

  always @(negedge clk) if (v1) begin
    n_cmp++;
    if (q1.size() == 0) begin
      n_bad++;
      $display("FAIL u1_out: unexpected beat %0h", o1);
    end else begin
      x1 = q1.pop_front();
      if (o1 !== x1) begin
        n_bad++;
        $display("FAIL u1_out: got %0h expected %0h", o1, x1);
      end
    end
  end

  always @(negedge clk) if (v8) begin
    n_cmp++;
    if (q8.size() == 0) begin
      n_bad++;
      $display("FAIL u8_out: unexpected beat %0h", o8);
    end else begin
      x8 = q8.pop_front();
      if (o8 !== x8) begin
        n_bad++;
        $display("FAIL u8_out: got %0h expected %0h", o8, x8);
      end
    end
  end

  always @(negedge clk) if (vr) begin
    n_cmp++;
    if (qr.size() == 0) begin
      n_bad++;
      $display("FAIL rx_out: unexpected beat %0h", orx);
    end else begin
      xr = qr.pop_front();
      if (orx !== xr) begin
        n_bad++;
        $display("FAIL rx_out: got %0h expected %0h", orx, xr);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    {s1, m1, e1, d1, b1, s8, m8, e8, st, mt, et, sr, mr} = '0;
    d8 = '0;
    dt = '0;
    seq = 8'b0111_0000;
    nxt = 8'b0100_1111;
    rxb = 7'b1001101;
    for (int k = 0; k < 31; k++) vec[k] = (k < 4) ? 4'h0 : 4'((k * 7 + 3) % 16);
    rst = 1'b1;
    tick;
    tick;
    chk("rst_out", 16'(o1), 16'h0);
    chk("rst_valid", 16'(v1), 16'h0);
    chk("rst_locked", 16'(l1), 16'h0);
    chk("rst_state_out", 16'(so1), 16'h0);
    rst = 1'b0;
    tick;
    // serial TX from all-ones seed
    s1 = 1'b1;
    tick;
    s1 = 1'b0;
    chk("tx_locked_after_start", 16'(l1), 16'h1);
    chk("tx_no_valid_without_en", 16'(v1), 16'h0);
    for (int i = 0; i < 8; i++) beat1(1'b0, seq[i]);
    for (int i = 0; i < 4; i++) beat1(1'b0, 1'b1);
    // restart mid-frame with a beat in the same cycle
    s1 = 1'b1;
    beat1(1'b0, seq[0]);
    s1 = 1'b0;
    for (int i = 1; i < 8; i++) beat1(1'b0, seq[i]);
`ifdef SCRAMBLER_BYPASS_EN
    b1 = 1'b1;
    for (int i = 0; i < 5; i++) beat1(1'b1, 1'b1);
    b1 = 1'b0;
    for (int i = 0; i < 8; i++) beat1(1'b0, nxt[i]);
`endif
    e1 = 1'b0;
    tick;
    // RX recovery interrupted by reset
    s1 = 1'b1;
    m1 = 1'b1;
    tick;
    s1 = 1'b0;
    for (int i = 0; i < 3; i++) beat1(1'b1, 1'b0);
    e1 = 1'b0;
    tick;
    chk("rx_unlocked_3bits", 16'(l1), 16'h0);
    rst = 1'b1;
    #2;
    chk("rst_mid_valid", 16'(v1), 16'h0);
    chk("rst_mid_locked", 16'(l1), 16'h0);
    rst = 1'b0;
    e1 = 1'b1;
    d1 = 1'b0;
    tick;
    chk("idle_ignores_en", 16'(v1), 16'h0);
    s1 = 1'b1;
    m1 = 1'b1;
    beat1(rxb[0], 1'b0);
    s1 = 1'b0;
    for (int i = 1; i < 6; i++) beat1(rxb[i], 1'b0);
    chk("rx_unlocked_6bits", 16'(l1), 16'h0);
    beat1(rxb[6], 1'b0);
    chk("rx_locked_7bits", 16'(l1), 16'h1);
    chk("rx_state_out", 16'(so1), 16'h59);
    beat1(1'b1, 1'b1);
    beat1(1'b0, 1'b0);
    e1 = 1'b0;
    tick;
    // 8-bit TX, start and beat together
    s8 = 1'b1;
    e8 = 1'b1;
    d8 = 8'h00;
    q8.push_back(8'h70);
    tick;
    s8 = 1'b0;
    d8 = 8'hFF;
    q8.push_back(8'hB0);
    tick;
    e8 = 1'b0;
    tick;
    // 4-bit TX -> RX loopback
    mr = 1'b1;
    for (int k = 0; k < 32; k++) begin
      st = (k == 0);
      et = (k < 31);
      dt = (k < 31) ? vec[k] : 4'h0;
      sr = (k == 1);
      if (k >= 1) qr.push_back(vec[k-1]);
      tick;
      if (k == 0) chk("tx4_first_beat", 16'(ot), 16'h6);
      if (k == 1) chk("rx_unlocked_beat1", 16'(lr), 16'h0);
      if (k == 2) begin
        chk("rx_locked_beat2", 16'(lr), 16'h1);
        chk("rx_state_out_loop", 16'(sor), 16'h36);
      end
    end
    sr = 1'b0;
    tick;
    tick;
    chk("q1_drained", 16'(q1.size()), 16'h0);
    chk("q8_drained", 16'(q8.size()), 16'h0);
    chk("qr_drained", 16'(qr.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scrambler_par.md
Name: scrambler_par

Overview:
- Parametrised 802.11a scrambler/descrambler, polynomial x^7 + x^4 + 1.
- Processes DATA_W bits per clock instead of one.
- Mode is selectable per frame:
  - TX: scramble from a programmed seed.
  - RX: descramble, recovering the LFSR state from the 7 leading zero SERVICE bits.
- Sits between the framing/SERVICE insertion stage and the convolutional encoder (TX), or between the Viterbi decoder and the deframer (RX).

Parameters:
- DATA_W, 1, bits per beat; legal range 1..16; bit 0 is the earliest bit in time.
- SEED, 7'b1011101, TX initial LFSR state {x7..x1} loaded on Start.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  frame-start pulse; latches Mode and (re)initialises the LFSR.
- Mode  input  1  0 = TX scramble, 1 = RX descramble with seed recovery; sampled only when Start=1.
- En  input  1  input beat valid.
- Data  input  DATA_W  input bits; bit 0 is processed first.
- Out  output  DATA_W  scrambled/descrambled bits, registered.
- Out_valid  output  1  Out holds a valid beat.
- Locked  output  1  LFSR state is known; TX after Start, RX after 7 bits absorbed.
- State_out  output  7  LFSR state {x7..x1} captured at the moment Locked rises.

Behaviour:
- Reset values: Out=0, Out_valid=0, Locked=0, State_out=0, LFSR=7'b0, bit counter=0, mode register=0, FSM=IDLE.
- Per-bit step, applied serially bit 0..DATA_W-1 within one cycle (unrolled combinational chain):
  - s = x7 ^ x4.
  - Normal: out = d ^ s; LFSR <= {x6..x1, s}.
  - Recovery (RX, counter<7): out = 0; LFSR <= {x6..x1, d}; counter += 1.
- Latency: Out/Out_valid are valid exactly 1 cycle after the En beat. Out_valid = registered En, but only if the FSM is not IDLE or Start was high that cycle.
- FSM states:
  - IDLE: Out_valid stays 0; En is ignored. Start=1 -> TX: load SEED, Locked=1, go RUN. Start=1 -> RX: LFSR=0, counter=0, Locked=0, go RECOVER.
  - RECOVER: each En beat consumes min(DATA_W, 7-counter) bits in recovery; remaining bits of the same beat are processed normally with the just-recovered state. When counter reaches 7: Locked=1, State_out = LFSR at that point, go RUN.
  - RUN: every En beat is processed normally; state holds when En=0.
- Start while RECOVER or RUN: aborts the current frame and reinitialises exactly as from IDLE. No beat of the old frame is output after that edge.
- Start and En in the same cycle: initialisation happens first, and that beat is processed from the fresh state.
- Mode changes without Start have no effect.
- LFSR state is never all-zero in TX. RX with an all-zero recovered state is passed through unchanged (output = input); no error is flagged.
- Reset mid-frame returns to IDLE immediately (asynchronous); the first clock after Reset deassertion produces no output.
- Counter is 3 bits and saturates at 7; it does not wrap.

Optional Feature:
- Macro: SCRAMBLER_BYPASS_EN.
- Defined: adds input port Bypass (1 bit).
  - While Bypass=1, Out = Data registered with the same 1-cycle latency.
  - Out_valid follows En regardless of FSM state.
  - LFSR and counter are frozen.
  - Deasserting Bypass resumes from the frozen state.
- Undefined: no Bypass port; behaviour exactly as above.

Test Plan:
- TX, DATA_W=1, SEED=7'b1111111, Start then 8 beats of Data=0 -> Out sequence 0,0,0,0,1,1,1,0; Locked=1 from the cycle after Start.
- TX, DATA_W=8, SEED=7'b1111111, Start+En same cycle with Data=8'h00 -> next cycle Out=8'b0111_0000 (bit0 first = 0000_1110 in time), Out_valid=1.
- Loopback: TX output (DATA_W=4, SEED=7'b1011101, 16-bit SERVICE of zeros + 108-bit random payload) fed to RX instance -> RX Locked after its 2nd beat; RX Out = 0 for the first 16 bits; payload matches bit-exact; RX State_out equals the TX LFSR state after 7 bits.
- Start asserted mid-frame in RUN (TX, DATA_W=1) -> LFSR reloads SEED; next 8 zero-input beats reproduce the first-frame sequence exactly.
- Reset pulsed during RECOVER after 3 bits -> Out_valid=0, Locked=0, counter=0. A new RX Start then requires a full 7 bits before Locked=1.
- With SCRAMBLER_BYPASS_EN, TX RUN, Bypass=1 for 5 beats of Data=1 -> Out=1 each beat; after Bypass=0, the zero-input output continues the sequence from where it stopped.
